gl5_box_avg_d: RTL and testbench
================================

Name: gl5_box_avg_d

Overview:
Upstream neighbour of the 2x2 decimation stage in the video downscaler chain. Computes the rounded 2x2 box average of each pixel quad and emits it on the beat at odd column / odd line. Every other beat passes its raw pixel through unchanged. The decimator that follows keeps only odd/odd beats, so the downscaled output is filtered rather than point-sampled. Input and output beats map 1:1, so tlast/tuser and downstream parity counters stay aligned.

Parameters:
D_WIDTH, 8, pixel component width in bits
MAX_WIDTH, 2048, maximum supported line length in pixels (even)
ADDR_WIDTH, 10, line-buffer address width; must satisfy 2**ADDR_WIDTH >= MAX_WIDTH/2

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
up_data  input  D_WIDTH  input pixel
up_valid  input  1  input beat valid
up_tlast  input  1  last pixel of line
up_tuser  input  1  start of frame (passed through)
up_ready  output  1  stage can accept a beat
down_data  output  D_WIDTH  raw pixel or 2x2 average
down_valid  output  1  output beat valid
down_tlast  output  1  registered copy of up_tlast
down_tuser  output  1  registered copy of up_tuser
down_ready  input  1  downstream accepts

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-low. Reset clears down_valid, down_data, down_tlast, down_tuser, pix_par, col and line_par to 0. Line RAM contents are not cleared.
- Acceptance: a beat is accepted when up_valid & up_ready. up_ready = ~down_valid | down_ready.
- Output register: single register stage, latency 1 cycle. On accept, load down_* and set down_valid. If down_valid & down_ready and no accept, clear down_valid. down_* is held stable while down_valid & ~down_ready.
- Counters (advance on accept only):
  - pix_par toggles each beat.
  - col increments after each odd-parity beat.
  - line_par toggles on tlast.
  - tlast clears pix_par and col.
  - tuser does NOT resync counters, so phase matches the downstream decimator's free-running parity counters.
- Even-parity beat: register prev_pix <= up_data. When line_par=1, issue a line-RAM read at col. Output = up_data.
- Odd-parity beat:
  - Form h = prev_pix + up_data (D_WIDTH+1 bits).
  - line_par=0: write h to RAM[col]; output = up_data.
  - line_par=1: output = (h + rd_data + 2) >> 2. The sum is computed in D_WIDTH+2 bits; the result always fits D_WIDTH.
- RAM read data is held until the next read, so stalls between the even and odd beat of a pair are harmless.
- Odd-length line: a final unpaired even beat with tlast passes raw; no RAM write occurs.
- Line longer than MAX_WIDTH: col wraps modulo 2**ADDR_WIDTH and averages alias. This is unsupported but must not hang.
- Simultaneous output drain and new accept: down_valid stays 1 and the register loads the new beat.
- Reset mid-line: counters restart at line 0, pixel 0. Stale RAM is never read before the first even line rewrites it.

Decomposition:
- Shared package gl_video_pkg holds the rounding constant (2) and the box-sum width function (D_WIDTH+2).
- Sub-module gl5_line_ram: simple dual-port RAM, (D_WIDTH+1) x 2**ADDR_WIDTH.
  - Synchronous write.
  - Synchronous read with read-enable; output is held when not enabled.
- gl5_box_avg_d contains the counters, the pairing logic and the output register.

Test Plan:
- 4x2 frame, no stall. Line0 = 10,20,30,40; line1 = 50,60,70,80 → output beats 10,20,30,40,50,35,70,55. tlast on beats 4 and 8; tuser on beat 1 only.
- Rounding, 2x2 frames with quad values:
  - 1,0/0,1 → 1
  - 1,0/0,0 → 0
  - 255,255/255,255 → 255
  - 0,3/0,0 → 1
- Random down_ready (50%) and up_valid gaps on the first frame → identical data sequence; no beat lost or duplicated; down_* stable while stalled.
- 3-pixel lines 10,20,30 / 40,50,60 → outputs 10,20,30,40,30,60. The third beat of each line passes raw and col resets.
- rst low for 1 cycle mid-line1 of the first frame → down_valid=0 immediately (asynchronously). The next frame yields the same outputs as the first scenario.
- Full-rate streaming with down_ready=1 → up_ready stays 1 and throughput is 1 beat per cycle.

Source files
------------

// File: rtl/gl_video_pkg.sv
// rtl/gl_video_pkg.sv - shared constants and helpers for the video downscaler chain
package gl_video_pkg;

    // Added to a four-pixel sum before the divide-by-four so the average rounds to nearest
    localparam int unsigned BOX_ROUND = 2;

    // Bits needed to hold the sum of four D_WIDTH pixels plus the rounding constant
    function automatic int box_sum_width(input int d_width);
        return d_width + 2;
    endfunction

endpackage

// File: rtl/gl5_line_ram.sv
// rtl/gl5_line_ram.sv - simple dual-port line buffer with held read data
module gl5_line_ram #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Synchronous write; contents are never cleared, the even line always rewrites first
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read; data is held between reads so stalls within a pair are harmless
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gl5_box_avg_d.sv
// rtl/gl5_box_avg_d.sv - 2x2 rounded box average emitted on odd/odd beats ahead of decimation
module gl5_box_avg_d
    import gl_video_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int MAX_WIDTH  = 2048,
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready
);

    localparam int SUM_W = box_sum_width(D_WIDTH);
    localparam int H_W   = D_WIDTH + 1;

    // The line buffer stores one horizontal pair sum per two pixels
    generate
        if ((2 ** ADDR_WIDTH) < (MAX_WIDTH / 2)) begin : g_bad_addr_width
            $error("gl5_box_avg_d: ADDR_WIDTH too small for MAX_WIDTH");
        end
    endgenerate

    logic                  pix_par_q,  pix_par_d;
    logic [ADDR_WIDTH-1:0] col_q,      col_d;
    logic                  line_par_q, line_par_d;
    logic [D_WIDTH-1:0]    prev_pix_q, prev_pix_d;

    logic [D_WIDTH-1:0]    down_data_q,  down_data_d;
    logic                  down_valid_q, down_valid_d;
    logic                  down_tlast_q, down_tlast_d;
    logic                  down_tuser_q, down_tuser_d;

    logic                  accept;
    logic [H_W-1:0]        h_sum;
    logic [H_W-1:0]        rd_data;
    logic [SUM_W-1:0]      box_sum;
    logic [D_WIDTH-1:0]    box_avg;
    logic                  ram_we;
    logic                  ram_re;

    assign up_ready = ~down_valid_q | down_ready;
    assign accept   = up_valid & up_ready;

    // Horizontal pair sum and rounded 2x2 average; the shifted sum always fits D_WIDTH
    assign h_sum   = {1'b0, prev_pix_q} + {1'b0, up_data};
    assign box_sum = SUM_W'(h_sum) + SUM_W'(rd_data) + SUM_W'(BOX_ROUND);
    assign box_avg = D_WIDTH'(box_sum >> 2);

    // Even lines store pair sums; odd lines fetch them on the even beat of each pair
    assign ram_we = accept &  pix_par_q & ~line_par_q;
    assign ram_re = accept & ~pix_par_q &  line_par_q;

    gl5_line_ram #(
        .DATA_WIDTH (H_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (col_q),
        .wr_data (h_sum),
        .rd_en   (ram_re),
        .rd_addr (col_q),
        .rd_data (rd_data)
    );

    // Free-running position counters; tuser deliberately leaves them alone
    always_comb begin
        pix_par_d  = pix_par_q;
        col_d      = col_q;
        line_par_d = line_par_q;
        prev_pix_d = prev_pix_q;
        if (accept) begin
            if (!pix_par_q) begin
                prev_pix_d = up_data;
            end
            if (up_tlast) begin
                pix_par_d  = 1'b0;
                col_d      = '0;
                line_par_d = ~line_par_q;
            end else begin
                pix_par_d = ~pix_par_q;
                if (pix_par_q) begin
                    col_d = col_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Output register: load on accept, drop valid on a drain with no new beat, else hold
    always_comb begin
        down_data_d  = down_data_q;
        down_valid_d = down_valid_q;
        down_tlast_d = down_tlast_q;
        down_tuser_d = down_tuser_q;
        if (accept) begin
            down_valid_d = 1'b1;
            down_tlast_d = up_tlast;
            down_tuser_d = up_tuser;
            if (pix_par_q && line_par_q) begin
                down_data_d = box_avg;
            end else begin
                down_data_d = up_data;
            end
        end else if (down_ready) begin
            down_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_par_q    <= 1'b0;
            col_q        <= '0;
            line_par_q   <= 1'b0;
            prev_pix_q   <= '0;
            down_data_q  <= '0;
            down_valid_q <= 1'b0;
            down_tlast_q <= 1'b0;
            down_tuser_q <= 1'b0;
        end else begin
            pix_par_q    <= pix_par_d;
            col_q        <= col_d;
            line_par_q   <= line_par_d;
            prev_pix_q   <= prev_pix_d;
            down_data_q  <= down_data_d;
            down_valid_q <= down_valid_d;
            down_tlast_q <= down_tlast_d;
            down_tuser_q <= down_tuser_d;
        end
    end

    assign down_data  = down_data_q;
    assign down_valid = down_valid_q;
    assign down_tlast = down_tlast_q;
    assign down_tuser = down_tuser_q;

endmodule

// File: tb/tb_gl5_box_avg_d.sv
// tb/tb_gl5_box_avg_d.sv - self-checking bench for gl5_box_avg_d
module tb_gl5_box_avg_d;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] up_data = '0;
    logic       up_valid = 1'b0;
    logic       up_tlast = 1'b0;
    logic       up_tuser = 1'b0;
    logic       up_ready;
    logic [7:0] down_data;
    logic       down_valid;
    logic       down_tlast;
    logic       down_tuser;
    logic       down_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    int    lpar_m = 0;
    int    prev_line[64];
    bit    rand_ready = 0;
    bit    rand_gaps = 0;
    bit    ignore_out = 0;
    int    stall_cnt = 0;
    int    out_cnt = 0;

    bit         held_pending = 0;
    logic [7:0] held_data;
    logic       held_last, held_user;

    logic [7:0] pix[64];

    gl5_box_avg_d #(.D_WIDTH(8), .MAX_WIDTH(2048), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_tlast   (up_tlast),
        .up_tuser   (up_tuser),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_tlast (down_tlast),
        .down_tuser (down_tuser),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            down_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: scoreboard compare on every transfer, stability while stalled
    always @(negedge clk) begin
        if (rst && !ignore_out) begin
            if (held_pending) begin
                checks++;
                assert (down_valid === 1'b1 && down_data === held_data &&
                        down_tlast === held_last && down_tuser === held_user)
                else begin
                    errors++;
                    $error("FAIL stall_hold: got v=%0b d=%0d l=%0b u=%0b need v=1 d=%0d l=%0b u=%0b",
                           down_valid, down_data, down_tlast, down_tuser, held_data, held_last, held_user);
                end
            end
            held_pending = down_valid && !down_ready;
            held_data = down_data;
            held_last = down_tlast;
            held_user = down_tuser;
            if (down_valid && down_ready) begin
                beat_t e;
                checks++;
                assert (exp_q.size() > 0)
                else begin
                    errors++;
                    $error("FAIL extra_beat: got d=%0d with no beat expected", down_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    out_cnt++;
                    checks++;
                    assert (down_data === e.data && down_tlast === e.last && down_tuser === e.user)
                    else begin
                        errors++;
                        $error("FAIL out_beat%0d: got d=%0d l=%0b u=%0b need d=%0d l=%0b u=%0b",
                               out_cnt, down_data, down_tlast, down_tuser, e.data, e.last, e.user);
                    end
                end
            end
        end else begin
            held_pending = 0;
        end
    end

    // Reference: raw pixel everywhere except odd pixel of an odd line, which is the rounded quad mean
    task automatic model_frame(input int w, input int h);
        beat_t b;
        for (int l = 0; l < h; l++) begin
            for (int i = 0; i < w; i++) begin
                int cur = int'(pix[l*w+i]);
                b.data = pix[l*w+i];
                if (lpar_m == 1 && (i % 2) == 1)
                    b.data = 8'((prev_line[i-1] + prev_line[i] + int'(pix[l*w+i-1]) + cur + 2) / 4);
                b.last = (i == w - 1);
                b.user = (l == 0 && i == 0);
                exp_q.push_back(b);
            end
            if (lpar_m == 0)
                for (int i = 0; i < w; i++) prev_line[i] = int'(pix[l*w+i]);
            lpar_m ^= 1;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_tlast = last;
        up_tuser = user;
        @(negedge clk);
        while (!up_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL up_ready_timeout: up_ready stuck at 0, need 1");
        end
        stall_cnt += n;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_tlast = 1'b0;
        up_tuser = 1'b0;
        if (rand_gaps)
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
    endtask

    task automatic send_frame(input int w, input int h);
        model_frame(w, h);
        for (int l = 0; l < h; l++)
            for (int i = 0; i < w; i++)
                send_beat(pix[l*w+i], logic'(i == w - 1), logic'(l == 0 && i == 0));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL %s_drain: %0d beats outstanding, need 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic load_4x2();
        logic [7:0] v[8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        for (int i = 0; i < 8; i++) pix[i] = v[i];
    endtask

    task automatic quad(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                        input logic [7:0] want, input string tag);
        beat_t last_e;
        pix[0] = a; pix[1] = b; pix[2] = c; pix[3] = d;
        send_frame(2, 2);
        last_e = exp_q[exp_q.size()-1];
        checks++;
        assert (last_e.data === want)
        else begin
            errors++;
            $error("FAIL %s_model: got %0d need %0d", tag, last_e.data, want);
        end
        drain(tag);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (down_valid === 1'b0 && down_data === 8'd0 && down_tlast === 1'b0 && down_tuser === 1'b0)
        else begin
            errors++;
            $error("FAIL reset_state: got v=%0b d=%0d l=%0b u=%0b need all 0", down_valid, down_data, down_tlast, down_tuser);
        end
        checks++;
        assert (up_ready === 1'b1)
        else begin
            errors++;
            $error("FAIL reset_ready: got %0b need 1", up_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 4x2 frame at full rate, expected beats written out by hand
        load_4x2();
        begin
            logic [7:0] want[8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd35, 8'd70, 8'd55};
            model_frame(4, 2);
            for (int i = 0; i < 8; i++) begin
                checks++;
                assert (exp_q[i].data === want[i])
                else begin
                    errors++;
                    $error("FAIL model_4x2_%0d: got %0d need %0d", i, exp_q[i].data, want[i]);
                end
            end
            exp_q.delete();
            lpar_m = 0;
        end
        stall_cnt = 0;
        send_frame(4, 2);
        drain("frame4x2");
        checks++;
        assert (stall_cnt == 0)
        else begin
            errors++;
            $error("FAIL full_rate_4x2: got %0d stall cycles need 0", stall_cnt);
        end

        // Rounding corners
        quad(8'd1, 8'd0, 8'd0, 8'd1, 8'd1, "round_a");
        quad(8'd1, 8'd0, 8'd0, 8'd0, 8'd0, "round_b");
        quad(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, "round_c");
        quad(8'd0, 8'd3, 8'd0, 8'd0, 8'd1, "round_d");

        // Random downstream backpressure and upstream gaps
        rand_ready = 1;
        rand_gaps = 1;
        load_4x2();
        send_frame(4, 2);
        drain("stall4x2");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) pix[i] = 8'($urandom_range(0, 255));
            send_frame(8, 4);
            drain("stall_rand");
        end
        rand_ready = 0;
        rand_gaps = 0;

        // Odd-length lines
        begin
            logic [7:0] v[6] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
            for (int i = 0; i < 6; i++) pix[i] = v[i];
            send_frame(3, 2);
            drain("odd_len");
        end

        // Asynchronous reset in the middle of line 1
        ignore_out = 1;
        load_4x2();
        for (int i = 0; i < 6; i++) send_beat(pix[i], logic'(i == 3), logic'(i == 0));
        #2;
        rst = 1'b0;
        #1;
        checks++;
        assert (down_valid === 1'b0)
        else begin
            errors++;
            $error("FAIL async_reset: down_valid got %0b need 0", down_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        lpar_m = 0;
        ignore_out = 0;
        @(posedge clk);
        #1;
        send_frame(4, 2);
        drain("after_reset");

        // Long full-rate stream
        stall_cnt = 0;
        for (int i = 0; i < 64; i++) pix[i] = 8'($urandom_range(0, 255));
        send_frame(16, 4);
        drain("stream");
        checks++;
        assert (stall_cnt == 0)
        else begin
            errors++;
            $error("FAIL full_rate_stream: got %0d stall cycles need 0", stall_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
